// File: rtl/matmul_seq_if.sv
// Bus bundle for matmul_seq: control handshake, matrix memory port and matrix_ops port.
// start/busy/done: start is sampled only while busy=0; busy stays high until the cycle done pulses.
interface matmul_seq_if #(
  parameter int AW = 8
);
  logic          start;
  logic [AW-1:0] a_base;
  logic [AW-1:0] b_base;
  logic [AW-1:0] c_base;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [255:0]  mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [255:0]  mem_wr_data;
  logic          mm_en;
  logic [5:0]    mm_op;
  logic [255:0]  mm_a;
  logic [255:0]  mm_b;
  logic [255:0]  mm_cin;
  logic [255:0]  mm_co;

  modport master (
    input  start, a_base, b_base, c_base, mem_rd_data, mm_co,
    output busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output mm_en, mm_op, mm_a, mm_b, mm_cin
  );

  modport slave (
    output start, a_base, b_base, c_base, mem_rd_data, mm_co,
    input  busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mm_en, mm_op, mm_a, mm_b, mm_cin
  );
endinterface

// File: rtl/matmul_seq.sv
// Row-by-row C = A*B sequencer feeding the combinational matrix_ops row-MAC unit.
// Optional MATMUL_SEQ_PERF_EN adds a saturating busy-cycle counter output perf_cycles.
module matmul_seq #(
  parameter int AW = 8,
  parameter int M  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  matmul_seq_if.master      bus,
  output logic [2:0]        dbg_state
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_LD_A = 3'd2,
    S_MAC  = 3'd3,
    S_WR_C = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [7:0] I_LAST = 8'(M - 1);

  state_t        state;
  state_t        state_nx;
  logic [7:0]    i;
  logic [2:0]    k;
  logic [255:0]  a_reg;
  logic [255:0]  acc;
  logic [AW-1:0] a_lat;
  logic [AW-1:0] b_lat;
  logic [AW-1:0] c_lat;
  logic          last_row;

  assign last_row  = (i == I_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) state_nx = S_RD_A;
      S_RD_A: state_nx = S_LD_A;
      S_LD_A: state_nx = S_MAC;
      S_MAC:  if (k == 3'd7) state_nx = S_WR_C;
      S_WR_C: state_nx = last_row ? S_DONE : S_RD_A;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i     <= '0;
      k     <= '0;
      a_reg <= '0;
      acc   <= '0;
      a_lat <= '0;
      b_lat <= '0;
      c_lat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_lat <= bus.a_base;
            b_lat <= bus.b_base;
            c_lat <= bus.c_base;
            i     <= '0;
          end
        end
        S_LD_A: begin
          a_reg <= bus.mem_rd_data;
          acc   <= '0;
          k     <= '0;
        end
        S_MAC: begin
          acc <= bus.mm_co;
          k   <= k + 3'd1;
        end
        S_WR_C: begin
          if (!last_row) i <= i + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Read data always lands one cycle after the request, so B row k arrives during MAC step k.
  always_comb begin
    bus.busy        = (state != S_IDLE);
    bus.done        = (state == S_DONE);
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mm_en       = 1'b0;
    bus.mm_op       = '0;
    bus.mm_a        = a_reg;
    bus.mm_b        = bus.mem_rd_data;
    bus.mm_cin      = acc;
    case (state)
      S_RD_A: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = a_lat + AW'(i);
      end
      S_LD_A: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = b_lat;
      end
      S_MAC: begin
        bus.mm_en = 1'b1;
        bus.mm_op = 6'(k) + 6'd1;
        if (k != 3'd7) begin
          bus.mem_rd_en   = 1'b1;
          bus.mem_rd_addr = b_lat + AW'(k) + AW'(1);
        end
      end
      S_WR_C: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = c_lat + AW'(i);
        bus.mem_wr_data = acc;
      end
      default: ;
    endcase
  end

`ifdef MATMUL_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE) begin
      if (bus.start) perf_cycles <= '0;
    end else if (perf_cycles != 16'hFFFF) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: memory and matrix_ops models, reference C = A*B, write scoreboard.
module tb_matmul_seq;
  localparam int AW = 8;
  localparam int M  = 8;
  localparam logic [7:0] A_BASE = 8'h10;
  localparam logic [7:0] B_BASE = 8'h40;
  localparam int EXP_CYC = 11 * M + 1;

  logic clk;
  logic rst_n;
  logic [2:0] dbg_state;
`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif

  matmul_seq_if #(.AW(AW)) bus ();

  matmul_seq #(.AW(AW), .M(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state  (dbg_state)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model and matrix_ops model
  logic [255:0] mem [256];
  logic [255:0] rd_data;
  logic [255:0] co_model;
  logic [AW-1:0] obs_addr_q[$];
  logic [255:0]  obs_data_q[$];
  int collide_cnt;

  assign bus.mem_rd_data = rd_data;
  assign bus.mm_co       = co_model;

  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_data <= mem[bus.mem_rd_addr];
    if (bus.mem_wr_en) begin
      obs_addr_q.push_back(bus.mem_wr_addr);
      obs_data_q.push_back(bus.mem_wr_data);
    end
    if (bus.mem_rd_en && bus.mem_wr_en) collide_cnt <= collide_cnt + 1;
  end

  always_comb begin
    co_model = bus.mm_cin;
    if (bus.mm_en && bus.mm_op >= 6'd1 && bus.mm_op <= 6'd8) begin
      for (int j = 0; j < 8; j++)
        co_model[32*j +: 32] = bus.mm_cin[32*j +: 32]
                             + bus.mm_a[32*(int'(bus.mm_op) - 1) +: 32] * bus.mm_b[32*j +: 32];
    end
  end

  // reference matrices and scoreboard
  logic [31:0]   ma [8][8];
  logic [31:0]   mb [8][8];
  logic [255:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_pass;
  int n_total;

  function automatic logic [255:0] ref_row(int r);
    logic [255:0] row;
    logic [31:0]  s;
    row = '0;
    for (int j = 0; j < 8; j++) begin
      s = 32'd0;
      for (int kk = 0; kk < 8; kk++) s = s + ma[r][kk] * mb[kk][j];
      row[32*j +: 32] = s;
    end
    return row;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_mem();
    for (int r = 0; r < 8; r++) begin
      logic [255:0] ra;
      logic [255:0] rb;
      for (int j = 0; j < 8; j++) begin
        ra[32*j +: 32] = ma[r][j];
        rb[32*j +: 32] = mb[r][j];
      end
      mem[8'(A_BASE + 8'(r))] = ra;
      mem[8'(B_BASE + 8'(r))] = rb;
    end
  endtask

  task automatic build_exp(input logic [7:0] cb);
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = 0; r < M; r++) begin
      exp_q.push_back(ref_row(r));
      exp_addr_q.push_back(8'(cb + 8'(r)));
    end
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check({tag, "_wr_count"}, 256'(obs_addr_q.size()), 256'(n_exp));
    for (int r = 0; r < n_exp; r++) begin
      logic [255:0] oa;
      logic [255:0] od;
      oa = 'x;
      od = 'x;
      if (r < obs_addr_q.size()) begin
        oa = 256'(obs_addr_q[r]);
        od = obs_data_q[r];
      end
      check($sformatf("%s_wr_addr%0d", tag, r), oa, 256'(exp_addr_q[r]));
      check($sformatf("%s_wr_data%0d", tag, r), od, exp_q[r]);
    end
  endtask

  task automatic start_op(input logic [7:0] cb);
    obs_addr_q.delete();
    obs_data_q.delete();
    @(negedge clk);
    bus.a_base = A_BASE;
    bus.b_base = B_BASE;
    bus.c_base = cb;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] cb, input int restart_at);
    int busy_cnt;
    int done_cnt;
    int done_at;
    build_exp(cb);
    start_op(cb);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int n = 1; n <= 150; n++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at = n;
      end
      bus.start = (n == restart_at);
      if (done_at > 0 && n >= done_at + 3) break;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_done_at"}, 256'(done_at), 256'(EXP_CYC));
    check({tag, "_done_cnt"}, 256'(done_cnt), 256'd1);
    check({tag, "_busy_cnt"}, 256'(busy_cnt), 256'(EXP_CYC));
    check_writes(tag, M);
`ifdef MATMUL_SEQ_PERF_EN
    check({tag, "_perf"}, 256'(perf_cycles), 256'(EXP_CYC));
`endif
  endtask

  task automatic rand_mats(input bit zero_a);
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        ma[r][j] = zero_a ? 32'd0 : $urandom;
        mb[r][j] = $urandom;
      end
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    collide_cnt = 0;
    rd_data     = '0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a_base = '0;
    bus.b_base = '0;
    bus.c_base = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  256'(bus.busy),      256'd0);
    check("rst_done",  256'(bus.done),      256'd0);
    check("rst_rd_en", 256'(bus.mem_rd_en), 256'd0);
    check("rst_wr_en", 256'(bus.mem_wr_en), 256'd0);
    check("rst_mm_en", 256'(bus.mm_en),     256'd0);
    check("rst_mm_op", 256'(bus.mm_op),     256'd0);
`ifdef MATMUL_SEQ_PERF_EN
    check("rst_perf",  256'(perf_cycles),   256'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // identity A, distinct B rows
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        ma[r][j] = (r == j) ? 32'd1 : 32'd0;
        mb[r][j] = {8'(r + 1), 8'(j), 16'hA5C3 ^ 16'(r * 37 + j)};
      end
    load_mem();
    for (int r = 0; r < 8; r++) begin
      logic [255:0] brow;
      brow = mem[8'(B_BASE + 8'(r))];
      check($sformatf("ident_ref%0d", r), ref_row(r), brow);
    end
    run_op("ident", 8'h80, 0);

    // zero A, random B
    rand_mats(1'b1);
    load_mem();
    run_op("zero", 8'h80, 0);

    // random A/B with start re-pulsed mid operation
    rand_mats(1'b0);
    load_mem();
    run_op("restart", 8'h90, 20);

    // reset during MAC of row 3 (row r MAC spans cycles 11r+3..11r+10)
    rand_mats(1'b0);
    load_mem();
    build_exp(8'hA0);
    start_op(8'hA0);
    for (int n = 1; n < 38; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  256'(bus.busy),      256'd0);
    check("mid_rst_rd_en", 256'(bus.mem_rd_en), 256'd0);
    check("mid_rst_wr_en", 256'(bus.mem_wr_en), 256'd0);
    check("mid_rst_mm_en", 256'(bus.mm_en),     256'd0);
    check("mid_rst_mm_op", 256'(bus.mm_op),     256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_idle", 256'(bus.busy), 256'd0);
    check_writes("mid_rst", 3);
    run_op("after_rst", 8'hA0, 0);

    // C base wraps through FF -> 00
    rand_mats(1'b0);
    load_mem();
    run_op("wrap", 8'hFE, 0);

    check("rd_wr_collide", 256'(collide_cnt), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequencer for 8x8 x 32-bit matrix multiply, C = A*B, directly upstream of the combinational matrix_ops row-MAC unit.
- Fetches A and B rows from a 256-bit-wide matrix memory and drives matrix_ops (mm_en, mm_op, a, b, cin).
- Accumulates matrix_ops' co across 8 steps per C row, then writes each completed C row back to memory.
- Start/busy/done handshake toward the core's control path.

Parameters:
AW, 8, matrix memory row-address width
M, 8, rows of A/C processed per operation (1..256); inner dimension and row width fixed at 8

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins operation when idle
a_base  input  AW  row address of A row 0
b_base  input  AW  row address of B row 0
c_base  input  AW  row address of C row 0
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
mem_rd_en  output  1  read request
mem_rd_addr  output  AW  read row address
mem_rd_data  input  256  read data, valid the cycle after mem_rd_en
mem_wr_en  output  1  write strobe
mem_wr_addr  output  AW  write row address
mem_wr_data  output  256  write data
mm_en  output  1  to matrix_ops enable
mm_op  output  6  to matrix_ops element select (1..8)
mm_a  output  256  to matrix_ops a
mm_b  output  256  to matrix_ops b
mm_cin  output  256  to matrix_ops cin
mm_co  input  256  from matrix_ops co

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mem_rd_en, mem_wr_en, mm_en=0; mm_op=0; i, k, a_reg, acc, latched bases=0.
- IDLE:
  - busy=0.
  - start=1 at an edge latches a_base/b_base/c_base, sets i=0, goes to RD_A.
  - start while busy is ignored.
- RD_A: mem_rd_en=1, mem_rd_addr=a_base+i; next LD_A.
- LD_A: a_reg<=mem_rd_data; acc<=0; k<=0; issue mem_rd_en=1, addr=b_base+0; next MAC.
- MAC, 8 cycles, k=0..7:
  - mm_en=1, mm_op=k+1, mm_a=a_reg, mm_b=mem_rd_data (B row k), mm_cin=acc; acc<=mm_co.
  - When k<7, issue read of b_base+k+1.
  - After k=7, next WR_C.
- WR_C:
  - mem_wr_en=1, mem_wr_addr=c_base+i, mem_wr_data=acc.
  - If i==M-1, next DONE; else i<=i+1, next RD_A.
- DONE: done=1 for exactly one cycle; next IDLE.
- Outside MAC: mm_en=0, mm_op=0 (matrix_ops then passes cin through).
- Latency: busy high for exactly 11*M+1 cycles, from the cycle after start is sampled through DONE. 8x8 case is 89 cycles.
- Address arithmetic wraps modulo 2^AW.
- acc takes mm_co verbatim, with no width interpretation in this block.
- Reset mid-operation: immediate return to IDLE, no further writes; a partially written C is left as-is.
- mem_rd_en and mem_wr_en are never asserted in the same cycle.

Optional Feature:
MATMUL_SEQ_PERF_EN:
- Defined: adds output perf_cycles[15:0]. It clears on an accepted start, increments every busy cycle, saturates at 16'hFFFF, and holds after done until the next start. Reset value is 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- A=identity (row i holds 32'd1 in element i, others 0), B rows distinct patterns -> each C row i written equals B row i. Exactly 8 writes, to c_base..c_base+7.
- A all zero, B random -> all 8 C rows written as 256'd0; done pulses one cycle, 89 cycles after start sampled.
- start reasserted at cycle 20 of an operation -> ignored; write sequence and done timing unchanged.
- rst_n low during MAC of row 3 -> outputs zero immediately, rows 3..7 never written, IDLE after release; a new start then runs a full operation.
- c_base=8'hFE, M=8 -> writes to FE, FF, 00..05 (wrap).
- MATMUL_SEQ_PERF_EN defined -> perf_cycles reads 89 after done; without the macro, the build has no perf_cycles port.
